user_module_host_driver: RTL and testbench
==========================================

// Module: user_module_host_driver
// PURPOSE
//  Host-side sequencer for the 64-word user functional module (UFM) port. It buffers a
//  64-word input frame from a host register port, plays it into the UFM load interface,
//  captures the 64 result words the UFM streams back, and reports done or timeout.
//  Sits between the AXI register slave and the UFM.
// PARAMETERS
//  WORDS           64     frame length in words; the UFM load/save index range is 0..WORDS-1
//  DATA_W          32     word width
//  ADDR_W          8      UFM address width (data_in_addr / data_out_addr)
//  TIMEOUT_CYCLES  4096   maximum cycles spent in any wait state before error
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous, active-high reset
//  wr_en           in   1       host write strobe into the input bank
//  wr_addr         in   6       input bank index
//  wr_data         in   DATA_W  input bank word
//  rd_addr         in   6       result bank index
//  rd_data         out  DATA_W  result bank word, combinational read of rd_addr
//  go              in   1       run request; a single-cycle pulse is sufficient
//  busy            out  1       high from the cycle after go is accepted until done or error
//  done            out  1       one-cycle pulse when a run completes cleanly
//  error           out  1       sticky timeout flag; cleared by the next accepted go
//  captured_cnt    out  7       number of result words captured in the current/last run
//  ufm_start       out  1       UFM start level
//  ufm_data_in_addr out ADDR_W  UFM load index
//  ufm_data_in     out  DATA_W  UFM load word, always in_bank[ufm_data_in_addr]
//  ufm_data_out_addr in ADDR_W  UFM save index, driven by the UFM
//  ufm_data_out    in   DATA_W  UFM save word
//  ufm_state       in   4       UFM state: 0 IDLE, 1 LOAD, 2 PROCESS, 3 SAVE, 4 DONE
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0; FSM = S_IDLE.
//   - Both banks are cleared to 0.
//   - The timeout counter is 0.
//  Host port:
//   - wr_en writes in_bank[wr_addr] only while busy=0; writes while busy=1 are dropped.
//   - rd_data is valid at any time; it reflects the bank contents during a run as they are captured.
//  go:
//   - Accepted only in S_IDLE with ufm_state==0.
//   - Otherwise it is ignored; go is not queued.
//  FSM, state by state:
//   - S_IDLE: go accepted -> clear error and captured_cnt, set busy, go to S_ARM.
//   - S_ARM:
//     - ufm_start=1 and ufm_data_in_addr=0.
//     - When ufm_state==1, go to S_LOAD.
//   - S_LOAD:
//     - ufm_data_in_addr increments by 1 every cycle, starting 0->1 on the first S_LOAD cycle.
//     - When ufm_data_in_addr==WORDS-1, hold the address and go to S_WAIT.
//     - Net effect: the UFM samples index 0 at least once and indices 1..63 exactly once.
//   - S_WAIT: when ufm_state==3, go to S_CAP. The capture rule below also applies in this same cycle.
//   - S_CAP:
//     - Every cycle with ufm_state==3 and ufm_data_out_addr<WORDS:
//       out_bank[ufm_data_out_addr] <= ufm_data_out, and captured_cnt increments.
//     - When ufm_state leaves 3, go to S_REL.
//   - S_REL:
//     - ufm_start=0.
//     - When ufm_state==0, pulse done for 1 cycle, clear busy, go to S_IDLE.
//  Timeout:
//   - The counter resets on every state change.
//   - In S_ARM, S_WAIT or S_REL, reaching TIMEOUT_CYCLES sets error, drops ufm_start,
//     clears busy and goes to S_IDLE. done is not pulsed.
//   - S_LOAD and S_CAP are self-timed and are not subject to the timeout.
//  Start rules:
//   - ufm_start is high only in S_ARM, S_LOAD, S_WAIT and S_CAP.
//   - After a drop, ufm_start stays low at least 1 cycle, so the next run gives a clean rising edge.
//  captured_cnt is 7 bits and saturates at 64; a clean run ends with 64.
//  Reset mid-run: asynchronous return to reset values and ufm_start=0. The UFM is resynchronised by its own reset.
// TESTING
//  1. Write in_bank[i]=i*3+1, pulse go, run against a UFM model that inverts each word.
//     -> out_bank[i]=~(i*3+1); done pulses once; captured_cnt=64; error=0.
//  2. The model holds ufm_state=0 forever after go.
//     -> error=1 exactly TIMEOUT_CYCLES cycles after entering S_ARM; ufm_start=0; busy=0; no done.
//  3. wr_en to address 5 with value 0xDEAD while busy, then read after the run.
//     -> in_bank[5] is unchanged; the UFM receives the original word at index 5.
//  4. Pulse go while busy, and pulse go while ufm_state!=0 in S_IDLE.
//     -> Both are ignored; exactly one run takes place.
//  5. Assert rst while in S_LOAD with ufm_data_in_addr=20.
//     -> ufm_start=0, all outputs 0 and banks cleared in the same cycle; a fresh go then completes normally.
//  6. Check the index sequence into the UFM model.
//     -> Every index 0..63 is seen in LOAD; index 63 is presented while ufm_state==1.

Source files
------------

// File: rtl/user_module_host_driver.sv
// ---------------------------------------------------------------------------------------------
// user_module_host_driver
//
// Host-side sequencer for the 64-word user functional module (UFM). The host fills an input
// bank through a simple register port and pulses go. The sequencer then raises ufm_start,
// walks ufm_data_in_addr through the frame while the UFM loads, captures the result words
// the UFM streams back into a result bank, and finally reports done, or error on a stall.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/addr/data     host write into the input bank (dropped while busy)
//   rd_addr, rd_data    combinational read of the result bank
//   go                  run request, accepted only when idle and the UFM reports IDLE
//   busy, done, error   run status; done is a one-cycle pulse, error is sticky until next go
//   captured_cnt        result words captured in the current/last run (saturates at WORDS)
//   ufm_start           start level towards the UFM
//   ufm_data_in_addr/_in  load index and the input-bank word at that index
//   ufm_data_out_addr/_out  save index and word from the UFM
//   ufm_state           UFM state: 0 IDLE, 1 LOAD, 2 PROCESS, 3 SAVE, 4 DONE
// ---------------------------------------------------------------------------------------------
module user_module_host_driver #(
  parameter int unsigned WORDS          = 64,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [6:0]        captured_cnt,
  output logic              ufm_start,
  output logic [ADDR_W-1:0] ufm_data_in_addr,
  output logic [DATA_W-1:0] ufm_data_in,
  input  logic [ADDR_W-1:0] ufm_data_out_addr,
  input  logic [DATA_W-1:0] ufm_data_out,
  input  logic [3:0]        ufm_state
);

  localparam int unsigned IdxW = 6;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(WORDS - 1);
  localparam logic [6:0]      CntFull  = 7'(WORDS);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] UfmIdle = 4'd0;
  localparam logic [3:0] UfmLoad = 4'd1;
  localparam logic [3:0] UfmSave = 4'd3;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StLoad,
    StWait,
    StCap,
    StRel
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              timed;
  logic              tmo_hit;
  logic              cap_en;

  logic [DATA_W-1:0] in_bank  [WORDS];
  logic [DATA_W-1:0] out_bank [WORDS];

  // Only the handshake waits can stall on the UFM; LOAD and CAP are paced by this block or
  // by the UFM's own save stream and are never timed out.
  assign timed   = (state_q == StArm) || (state_q == StWait) || (state_q == StRel);
  assign tmo_hit = timed && (tmo_q == TmoLast);

  // Capture is also live in the WAIT cycle that first sees SAVE, so the first word is kept.
  assign cap_en  = ((state_q == StWait) || (state_q == StCap)) &&
                   (ufm_state == UfmSave) &&
                   (ufm_data_out_addr < ADDR_W'(WORDS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go && (ufm_state == UfmIdle)) begin
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (ufm_state == UfmLoad) begin
          state_d = StLoad;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StLoad: begin
        if (idx_q == LastIdx) begin
          state_d = StWait;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StWait: begin
        if (ufm_state == UfmSave) begin
          state_d = StCap;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StCap: begin
        if (ufm_state != UfmSave) begin
          state_d = StRel;
        end
      end
      StRel: begin
        if (ufm_state == UfmIdle) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Load index rests at 0 whenever a run is not loading or draining.
    if ((state_d == StIdle) || (state_d == StArm)) begin
      idx_d = '0;
    end

    if (cap_en && (cnt_q != CntFull)) begin
      cnt_d = cnt_q + 7'd1;
    end

    // Counter restarts on every state change and only runs in the timed waits.
    if ((state_d != state_q) || !timed) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    // Registered from the next state so the outputs are glitch-free. Leaving through IDLE
    // guarantees at least one low cycle on ufm_start between runs.
    busy_d  = (state_d != StIdle);
    start_d = (state_d == StArm) || (state_d == StLoad) ||
              (state_d == StWait) || (state_d == StCap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        in_bank[i] <= '0;
      end
    end else if (wr_en && !busy_q) begin
      in_bank[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        out_bank[i] <= '0;
      end
    end else if (cap_en) begin
      out_bank[ufm_data_out_addr[IdxW-1:0]] <= ufm_data_out;
    end
  end

  assign rd_data          = out_bank[rd_addr];
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign captured_cnt     = cnt_q;
  assign ufm_start        = start_q;
  assign ufm_data_in_addr = ADDR_W'(idx_q);
  assign ufm_data_in      = in_bank[idx_q];

endmodule

// File: tb/tb_user_module_host_driver.sv
// Bench for user_module_host_driver: a behavioural UFM plays the LOAD/PROCESS/SAVE handshake,
// inverting every word it loads; a host-side shadow of the input bank predicts every result.
module tb_user_module_host_driver;

  localparam int unsigned WORDS  = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [5:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              go;
  logic              busy;
  logic              done;
  logic              error;
  logic [6:0]        captured_cnt;
  logic              ufm_start;
  logic [ADDR_W-1:0] ufm_data_in_addr;
  logic [DATA_W-1:0] ufm_data_in;
  logic [ADDR_W-1:0] ufm_data_out_addr;
  logic [DATA_W-1:0] ufm_data_out;
  logic [3:0]        ufm_state;

  always #5 clk = ~clk;

  user_module_host_driver #(
    .WORDS          (WORDS),
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .go                (go),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .captured_cnt      (captured_cnt),
    .ufm_start         (ufm_start),
    .ufm_data_in_addr  (ufm_data_in_addr),
    .ufm_data_in       (ufm_data_in),
    .ufm_data_out_addr (ufm_data_out_addr),
    .ufm_data_out      (ufm_data_out),
    .ufm_state         (ufm_state)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Shadow of what the host believes is in the input bank.
  logic [DATA_W-1:0] in_model [WORDS];
  // What the UFM model actually loaded, and how often each index was offered during LOAD.
  logic [DATA_W-1:0] rx [WORDS];
  int                seen [WORDS];
  int                order_q [$];

  int   done_seen   = 0;
  int   start_rises = 0;
  logic start_prev  = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (ufm_start === 1'b1 && start_prev !== 1'b1) start_rises++;
    start_prev = ufm_start;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic fill(input bit ramp);
    for (int i = 0; i < int'(WORDS); i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 6'(i);
      wr_data = ramp ? DATA_W'(i * 3 + 1) : $urandom;
      in_model[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Behavioural UFM: load the frame, process, stream back the inverted words, then finish.
  task automatic ufm_run(input bit poke_wr, input bit poke_go, input bit do_rst,
                         output bit aborted);
    int          guard;
    int          n;
    int          bad;
    logic [7:0]  a;
    aborted = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) begin
      seen[i] = 0;
      rx[i]   = 'x;
    end
    order_q.delete();

    guard = 0;
    while (ufm_start !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("start_raised", 32'(ufm_start), 32'd1);
    check("arm_index", 32'(ufm_data_in_addr), 32'd0);

    ufm_state = 4'd1;
    guard = 0;
    a = '0;
    do begin
      @(negedge clk);
      guard++;
      a = ufm_data_in_addr;
      if (a < 8'(WORDS)) begin
        seen[a]++;
        rx[a] = ufm_data_in;
        order_q.push_back(int'(a));
      end
      // A host write while busy must be dropped; issue it before index 5 is offered.
      wr_en   = poke_wr && (guard == 1);
      wr_addr = 6'd5;
      wr_data = 32'hDEAD;
      if (do_rst && a == 8'd20) begin
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check("rst_start", 32'(ufm_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cnt", 32'(captured_cnt), 32'd0);
        check("rst_in_addr", 32'(ufm_data_in_addr), 32'd0);
        check("rst_in_bank0", ufm_data_in, 32'd0);
        bad = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
          rd_addr = 6'(i);
          #1;
          if (rd_data !== '0) bad++;
        end
        check("rst_out_bank_clear", 32'(bad), 32'd0);
        ufm_state = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) in_model[i] = '0;
        aborted = 1'b1;
        return;
      end
    end while (a != 8'(WORDS - 1) && guard < 200);
    wr_en = 1'b0;
    check("load_reached_last", 32'(a), 32'(WORDS - 1));

    ufm_state = 4'd2;
    n = $urandom_range(1, 6);
    for (int c = 0; c < n; c++) begin
      if (poke_go) go = (c == 0);
      @(negedge clk);
    end
    go = 1'b0;

    for (int i = 0; i < int'(WORDS); i++) begin
      ufm_state         = 4'd3;
      ufm_data_out_addr = 8'(i);
      ufm_data_out      = ~rx[i];
      @(negedge clk);
    end
    // Repeat a valid word (count must saturate) and offer an out-of-range index (ignored).
    ufm_data_out_addr = 8'd0;
    ufm_data_out      = ~rx[0];
    @(negedge clk);
    ufm_data_out_addr = 8'(WORDS + $urandom_range(0, 150));
    ufm_data_out      = $urandom;
    @(negedge clk);
    ufm_state = 4'd4;

    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (ufm_start !== 1'b0 && guard < 50);
    check("start_dropped", 32'(ufm_start), 32'd0);
    ufm_state = 4'd0;
  endtask

  task automatic check_run(input int done0, input int rises0);
    int bad;
    int prev;
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_seen - done0), 32'd1);
    check("single_start", 32'(start_rises - rises0), 32'd1);
    check("busy_after_run", 32'(busy), 32'd0);
    check("error_after_run", 32'(error), 32'd0);
    check("captured_cnt", 32'(captured_cnt), 32'(WORDS));
    check("start_after_run", 32'(ufm_start), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(WORDS); i++) if (rx[i] !== in_model[i]) bad++;
    check("ufm_loaded_words", 32'(bad), 32'd0);
    bad = 0;
    if (seen[0] < 1) bad++;
    for (int i = 1; i < int'(WORDS); i++) if (seen[i] != 1) bad++;
    prev = 0;
    foreach (order_q[k]) begin
      if (order_q[k] < prev) bad++;
      prev = order_q[k];
    end
    check("load_index_sequence", 32'(bad), 32'd0);
    check("last_index_in_load", 32'(seen[WORDS-1]), 32'd1);
    for (int i = 0; i < int'(WORDS); i++) begin
      @(negedge clk);
      rd_addr = 6'(i);
      #1;
      check($sformatf("rd_data[%0d]", i), rd_data, ~in_model[i]);
    end
  endtask

  initial begin
    int  d0;
    int  r0;
    int  k;
    bit  ab;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    go = 1'b0;
    ufm_data_out_addr = '0;
    ufm_data_out = '0;
    ufm_state = 4'd0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_cnt", 32'(captured_cnt), 32'd0);
    check("reset_start", 32'(ufm_start), 32'd0);
    check("reset_in_addr", 32'(ufm_data_in_addr), 32'd0);
    check("reset_in_data", ufm_data_in, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame; a host write and a second go are issued mid-run and must be ignored.
    fill(1'b1);
    d0 = done_seen;
    r0 = start_rises;
    pulse_go();
    check("busy_after_go", 32'(busy), 32'd1);
    ufm_run(1'b1, 1'b1, 1'b0, ab);
    check_run(d0, r0);

    // go while the UFM is not IDLE is dropped and not queued.
    ufm_state = 4'd4;
    r0 = start_rises;
    pulse_go();
    repeat (3) @(negedge clk);
    ufm_state = 4'd0;
    repeat (3) @(negedge clk);
    check("go_ignored_busy", 32'(busy), 32'd0);
    check("go_ignored_start", 32'(start_rises - r0), 32'd0);

    // Rerun without refilling: the dropped write must not have reached the input bank.
    d0 = done_seen;
    r0 = start_rises;
    pulse_go();
    ufm_run(1'b0, 1'b0, 1'b0, ab);
    check("dropped_write_idx5", rx[5], 32'd16);
    check_run(d0, r0);

    // UFM never leaves IDLE: error exactly TMO cycles after entering ARM.
    d0 = done_seen;
    pulse_go();
    k = 0;
    while (error !== 1'b1 && k < int'(TMO) + 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'(TMO));
    check("timeout_start", 32'(ufm_start), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("timeout_no_done", 32'(done_seen - d0), 32'd0);
    check("timeout_sticky", 32'(error), 32'd1);

    // Random frame; the accepted go clears the sticky error.
    fill(1'b0);
    d0 = done_seen;
    r0 = start_rises;
    pulse_go();
    check("error_cleared_by_go", 32'(error), 32'd0);
    ufm_run(1'b0, 1'b0, 1'b0, ab);
    check_run(d0, r0);

    // Reset in the middle of LOAD, then a fresh run must complete normally.
    fill(1'b0);
    pulse_go();
    ufm_run(1'b0, 1'b0, 1'b1, ab);
    check("reset_aborted_run", 32'(ab), 32'd1);
    fill(1'b0);
    d0 = done_seen;
    r0 = start_rises;
    pulse_go();
    ufm_run(1'b0, 1'b0, 1'b0, ab);
    check_run(d0, r0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
